// File: rtl/conv_resta_bcd_pkg.sv
// Shared definitions for the subtractor-result to BCD converter:
// state encoding, BCD nibble constants and derived sizing helpers.
package conv_resta_bcd_pkg;

    // Controller states; completion is signalled by a registered pulse,
    // so there is no dedicated DONE state.
    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Width of one BCD digit.
    localparam int NIBBLE_W = 4;

    // Double-dabble correction: a digit of 5 or more would overflow past 9
    // after the next doubling, so 3 is added to it before the shift.
    localparam logic [NIBBLE_W-1:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [NIBBLE_W-1:0] ADJ_CONST     = 4'd3;

    // One shift per bit of the (w+1)-bit magnitude.
    function automatic int iter_count(input int w);
        return w + 1;
    endfunction

    // BCD digit field on top of the (w+1)-bit binary field.
    function automatic int sreg_width(input int w, input int digits);
        return digits * NIBBLE_W + w + 1;
    endfunction

endpackage

// File: rtl/conv_resta_bcd_ajuste_bcd.sv
// Combinational double-dabble digit correction: adds 3 to a BCD digit
// that is 5 or more, passes smaller digits through unchanged.
module ajuste_bcd
    import conv_resta_bcd_pkg::*;
(
    input  logic [NIBBLE_W-1:0] digit,
    output logic [NIBBLE_W-1:0] adjusted
);

    // Inputs stay within 0..9 during conversion, so digit + 3 never wraps.
    assign adjusted = (digit >= ADJ_THRESHOLD) ? (digit + ADJ_CONST) : digit;

endmodule

// File: rtl/conv_resta_bcd.sv
// Converts the ripple subtractor's {borrow, diff} result into sign plus
// two BCD digits using an iterative shift-add-3 (double-dabble) engine.
// The digits and sign are held for the display driver between conversions,
// with a start/busy/done handshake toward the control logic.
module conv_resta_bcd
    import conv_resta_bcd_pkg::*;
#(
    parameter int W      = 5,
    parameter int DIGITS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W:0]   x,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         neg,
    output logic [3:0]   tens,
    output logic [3:0]   units
);

    localparam int ITERS = iter_count(W);
    localparam int SR_W  = sreg_width(W, DIGITS);
    localparam int BCD_W = DIGITS * NIBBLE_W;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    // Counter value during the final shift of a conversion.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    // Bit positions of the two displayed digits inside the shift register.
    localparam int UNITS_LSB = W + 1;
    localparam int TENS_LSB  = W + 1 + NIBBLE_W;

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              neg_q, neg_d;
    logic [3:0]        tens_q, tens_d;
    logic [3:0]        units_q, units_d;

    logic [W:0]        mag;
    logic [BCD_W-1:0]  adj_bcd;
    logic [SR_W-1:0]   adjusted_sreg;
    logic [SR_W-1:0]   shifted_sreg;

    // Two's-complement negate of a borrowed result gives its magnitude;
    // x = 100000 maps to 32, which still fits the W+1 bit field.
    assign mag = x[W] ? (-x) : x;

    // One correction cell per BCD digit of the shift register.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        ajuste_bcd u_adj (
            .digit    (sreg_q[W + 1 + NIBBLE_W*d +: NIBBLE_W]),
            .adjusted (adj_bcd[NIBBLE_W*d +: NIBBLE_W])
        );
    end

    // Correct every digit first, then double the whole register; the
    // magnitude MSB moves into the units digit on each shift.
    assign adjusted_sreg = {adj_bcd, sreg_q[W:0]};
    assign shifted_sreg  = adjusted_sreg << 1;

    // Next-state and datapath update; everything holds unless changed below.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        neg_d   = neg_q;
        tens_d  = tens_q;
        units_d = units_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = x[W];
                    sreg_d  = {{BCD_W{1'b0}}, mag};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                sreg_d = shifted_sreg;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Publish the finished digits in the same cycle done rises.
                    neg_d   = sign_q;
                    tens_d  = shifted_sreg[TENS_LSB +: 4];
                    units_d = shifted_sreg[UNITS_LSB +: 4];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift register, counter, handshake flags and held display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            neg_q   <= neg_d;
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign neg   = neg_q;
    assign tens  = tens_q;
    assign units = units_q;

endmodule

// File: tb/tb_conv_resta_bcd.sv
// Self-checking bench for conv_resta_bcd: handshake timing, sign/magnitude
// and BCD results against an arithmetic reference model.
module tb_conv_resta_bcd;

    localparam int W = 5;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W:0]   x;
    logic         start;
    logic         busy;
    logic         done;
    logic         neg;
    logic [3:0]   tens;
    logic [3:0]   units;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_resta_bcd #(.W(W), .DIGITS(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .start (start),
        .busy  (busy),
        .done  (done),
        .neg   (neg),
        .tens  (tens),
        .units (units)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Magnitude of a {borrow, diff} word read as a signed (W+1)-bit value.
    function automatic int model_mag(input logic [W:0] v);
        int raw;
        raw = int'(v);
        if (v[W]) return (1 << (W + 1)) - raw;
        return raw;
    endfunction

    // Launch one conversion from an idle cycle and wait (bounded) for done.
    // Scrambles x while busy. Returns in the done cycle; lat = -1 on timeout.
    task automatic do_conv(input logic [W:0] xv, output logic n,
                           output logic [3:0] t, output logic [3:0] u,
                           output int lat);
        x = xv;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            x = (W+1)'($urandom);
            step();
        end
        n = neg;
        t = tens;
        u = units;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        x = '0;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || neg !== 1'b0 || tens !== 4'd0 || units !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b neg=%b tens=%0d units=%0d, want all 0",
                     busy, done, neg, tens, units);
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            x = (W+1)'($urandom);
            step();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || neg !== 1'b0 || tens !== 4'd0 || units !== 4'd0) begin
                failures++;
                $display("FAIL idle_quiet[%0d]: got busy=%b done=%b neg=%b tens=%0d units=%0d, want all 0",
                         c, busy, done, neg, tens, units);
            end
        end
    endtask

    task automatic test_positive();
        x = 6'b001101;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL pos_busy_window[cycle %0d]: got busy=%b done=%b, want busy=1 done=0",
                         c, busy, done);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL pos_done_cycle7: got done=%b busy=%b, want done=1 busy=0", done, busy);
        end
        checks++;
        if (neg !== 1'b0 || tens !== 4'd1 || units !== 4'd3) begin
            failures++;
            $display("FAIL pos_result: got neg=%b tens=%0d units=%0d, want neg=0 tens=1 units=3",
                     neg, tens, units);
        end
        step();
        checks++;
        if (done !== 1'b0 || neg !== 1'b0 || tens !== 4'd1 || units !== 4'd3) begin
            failures++;
            $display("FAIL pos_pulse_hold: got done=%b neg=%b tens=%0d units=%0d, want done=0 neg=0 tens=1 units=3",
                     done, neg, tens, units);
        end
    endtask

    task automatic test_negative();
        logic [W:0] xs [4];
        logic       en [4];
        int         et [4];
        int         eu [4];
        logic       n;
        logic [3:0] t, u;
        int         lat;
        xs[0] = 6'b110011; en[0] = 1'b1; et[0] = 1; eu[0] = 3;
        xs[1] = 6'b100001; en[1] = 1'b1; et[1] = 3; eu[1] = 1;
        xs[2] = 6'b000000; en[2] = 1'b0; et[2] = 0; eu[2] = 0;
        xs[3] = 6'b100000; en[3] = 1'b1; et[3] = 3; eu[3] = 2;
        for (int i = 0; i < 4; i++) begin
            do_conv(xs[i], n, t, u, lat);
            checks++;
            if (lat != LAT || n !== en[i] || int'(t) != et[i] || int'(u) != eu[i]) begin
                failures++;
                $display("FAIL neg_case[x=%b]: got lat=%0d neg=%b tens=%0d units=%0d, want lat=%0d neg=%b tens=%0d units=%0d",
                         xs[i], lat, n, t, u, LAT, en[i], et[i], eu[i]);
            end
        end
        step();
    endtask

    // Expects to start idle with held outputs neg=1 tens=3 units=2.
    task automatic test_handshake();
        x = 6'b001101;
        start = 1'b1;
        step();
        for (int c = 1; c <= 6; c++) begin
            if (c == 2 || c == 4) begin
                start = 1'b1;
                x = 6'b110000 | (W+1)'(c);
            end else begin
                start = 1'b0;
                x = (W+1)'($urandom);
            end
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || neg !== 1'b1 || tens !== 4'd3 || units !== 4'd2) begin
                failures++;
                $display("FAIL hs_hold[cycle %0d]: got busy=%b done=%b neg=%b tens=%0d units=%0d, want busy=1 done=0 neg=1 tens=3 units=2",
                         c, busy, done, neg, tens, units);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || neg !== 1'b0 || tens !== 4'd1 || units !== 4'd3) begin
            failures++;
            $display("FAIL hs_first_result: got done=%b neg=%b tens=%0d units=%0d, want done=1 neg=0 tens=1 units=3",
                     done, neg, tens, units);
        end
        x = 6'b011111;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 8; c <= 13; c++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL hs_b2b_busy[cycle %0d]: got busy=%b done=%b, want busy=1 done=0",
                         c, busy, done);
            end
            x = (W+1)'($urandom);
            step();
        end
        checks++;
        if (done !== 1'b1 || neg !== 1'b0 || tens !== 4'd3 || units !== 4'd1) begin
            failures++;
            $display("FAIL hs_second_result: got done=%b neg=%b tens=%0d units=%0d, want done=1 neg=0 tens=3 units=1",
                     done, neg, tens, units);
        end
        step();
    endtask

    task automatic test_reset_mid();
        x = 6'b001101;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || neg !== 1'b0 || tens !== 4'd0 || units !== 4'd0) begin
            failures++;
            $display("FAIL midrst_clear: got busy=%b done=%b neg=%b tens=%0d units=%0d, want all 0",
                     busy, done, neg, tens, units);
        end
        for (int c = 0; c < 12; c++) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || tens !== 4'd0 || units !== 4'd0) begin
                failures++;
                $display("FAIL midrst_no_done[%0d]: got done=%b busy=%b tens=%0d units=%0d, want 0",
                         c, done, busy, tens, units);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] pending[$];
        logic [W:0] xe;
        int         m;
        start = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            x = (W+1)'($urandom);
            if (k % LAT == 0) pending.push_back(x);
            step();
            if (k == 20) start = 1'b0;
            checks++;
            if ((k + 1) % LAT == 0) begin
                xe = pending.pop_front();
                m = model_mag(xe);
                if (done !== 1'b1 || neg !== xe[W] || int'(tens) != m / 10 || int'(units) != m % 10) begin
                    failures++;
                    $display("FAIL b2b_result[cycle %0d x=%b]: got done=%b neg=%b tens=%0d units=%0d, want done=1 neg=%b tens=%0d units=%0d",
                             k + 1, xe, done, neg, tens, units, xe[W], m / 10, m % 10);
                end
            end else begin
                if (done !== 1'b0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_gap[cycle %0d]: got done=%b busy=%b, want done=0 busy=1",
                             k + 1, done, busy);
                end
            end
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stop: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_random();
        logic [W:0] xv;
        logic       n;
        logic [3:0] t, u;
        int         lat, m;
        for (int i = 0; i < 40; i++) begin
            xv = (W+1)'($urandom);
            do_conv(xv, n, t, u, lat);
            m = model_mag(xv);
            checks++;
            if (lat != LAT || n !== xv[W] || int'(t) != m / 10 || int'(u) != m % 10) begin
                failures++;
                $display("FAIL random[x=%b]: got lat=%0d neg=%b tens=%0d units=%0d, want lat=%0d neg=%b tens=%0d units=%0d",
                         xv, lat, n, t, u, LAT, xv[W], m / 10, m % 10);
            end
        end
        step();
    endtask

    task automatic test_sweep();
        logic [W:0] xv;
        logic       n;
        logic [3:0] t, u;
        int         lat, diff, got;
        logic       exp_neg;
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                xv = (W+1)'(a - b);
                exp_neg = (a < b);
                diff = (a >= b) ? (a - b) : (b - a);
                do_conv(xv, n, t, u, lat);
                got = int'(t) * 10 + int'(u);
                checks++;
                if (lat != LAT || n !== exp_neg || got != diff || t > 4'd9 || u > 4'd9) begin
                    failures++;
                    $display("FAIL sweep[a=%0d b=%0d]: got lat=%0d neg=%b value=%0d (tens=%0d units=%0d), want lat=%0d neg=%b value=%0d",
                             a, b, lat, n, got, t, u, LAT, exp_neg, diff);
                end
            end
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        x = '0;
        test_reset();
        test_positive();
        test_negative();
        test_handshake();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
